// File: rtl/mips_memwrite_checker.sv
// Data-memory write-port monitor: compares observed stores against an in-order
// queue of expected (address, data) pairs and latches a sticky PASS/FAIL verdict.
module mips_memwrite_checker #(
  parameter int              AW          = 32,
  parameter int              DW          = 32,
  parameter int              DEPTH       = 8,
  parameter int              TIMEOUT     = 1000,
  parameter bit              IGNORE_EN   = 1'b1,
  parameter logic [AW-1:0]   IGNORE_ADDR = AW'(80)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          exp_push,
  input  logic [AW-1:0] exp_addr,
  input  logic [DW-1:0] exp_data,
  output logic          exp_full,
  input  logic          start,
  input  logic          clear,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [1:0]    err_code,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_data,
  output logic [15:0]   match_cnt,
  output logic [15:0]   ign_cnt,
  output logic          overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, PASS_S, FAIL_S} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wptr, rptr;
  logic [TW-1:0]   timer, timer_n;
  logic [AW-1:0]   q_addr [DEPTH];
  logic [DW-1:0]   q_data [DEPTH];

  logic head_hit, ign_hit, pop, is_match, is_ign, mism, tmo, accept, drop, open_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    pop      = 1'b0;
    is_match = 1'b0;
    is_ign   = 1'b0;
    mism     = 1'b0;
    tmo      = 1'b0;
    head_hit = (dataadr == q_addr[rptr]) && (writedata == q_data[rptr]);
    ign_hit  = IGNORE_EN && (dataadr == IGNORE_ADDR);
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          timer_n = '0;
        end
      end
      RUN: begin
        if (count == '0) begin
          state_n = PASS_S;
        end else if (memwrite && !ign_hit && head_hit) begin
          pop      = 1'b1;
          is_match = 1'b1;
          timer_n  = '0;
        end else if (memwrite && !ign_hit) begin
          mism    = 1'b1;
          state_n = FAIL_S;
        end else begin
          // Ignored scratch stores still count as "no progress" for the timer.
          is_ign  = memwrite;
          timer_n = timer + 1'b1;
          if (timer == TMO_LAST) begin
            tmo     = 1'b1;
            state_n = FAIL_S;
          end
        end
      end
      default: ;
    endcase
    open_q = (state == IDLE) || (state == RUN);
    accept = exp_push && open_q && ((count != FULL_CNT) || pop);
    drop   = exp_push && open_q && (count == FULL_CNT) && !pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      timer     <= '0;
      match_cnt <= '0;
      ign_cnt   <= '0;
      overflow  <= 1'b0;
      err_code  <= 2'd0;
      err_addr  <= '0;
      err_data  <= '0;
    end else if (clear) begin
      state     <= IDLE;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      timer     <= '0;
      match_cnt <= '0;
      ign_cnt   <= '0;
      overflow  <= 1'b0;
      err_code  <= 2'd0;
      err_addr  <= '0;
      err_data  <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
      if (state == IDLE && start) begin
        match_cnt <= '0;
        ign_cnt   <= '0;
      end
      if (is_match) match_cnt <= sat_inc(match_cnt);
      if (is_ign)   ign_cnt   <= sat_inc(ign_cnt);
      if (mism) begin
        err_code <= 2'd1;
        err_addr <= dataadr;
        err_data <= writedata;
      end else if (tmo) begin
        err_code <= 2'd2;
      end
    end
  end

  // Queue storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_addr[wptr] <= exp_addr;
      q_data[wptr] <= exp_data;
    end
  end

  assign exp_full = (count == FULL_CNT);
  assign pass     = (state == PASS_S);
  assign fail     = (state == FAIL_S);
  assign done     = pass || fail;

endmodule

// File: tb/tb_mips_memwrite_checker.sv
// Bench for mips_memwrite_checker: directed scenarios plus randomized store
// traffic, all outputs compared each cycle against a queue-based reference model.
module tb_mips_memwrite_checker;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 20;
  localparam logic [31:0] IGN = 32'd80;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;
  localparam int M_FAIL = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic exp_push = 1'b0, start = 1'b0, clear = 1'b0, memwrite = 1'b0;
  logic [AW-1:0] exp_addr = '0, dataadr = '0;
  logic [DW-1:0] exp_data = '0, writedata = '0;
  logic exp_full, done, pass, fail, overflow;
  logic [1:0] err_code;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_data;
  logic [15:0] match_cnt, ign_cnt;

  mips_memwrite_checker #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT),
    .IGNORE_EN(1'b1), .IGNORE_ADDR(IGN)
  ) dut (
    .clk(clk), .reset(reset),
    .exp_push(exp_push), .exp_addr(exp_addr), .exp_data(exp_data), .exp_full(exp_full),
    .start(start), .clear(clear),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done), .pass(pass), .fail(fail),
    .err_code(err_code), .err_addr(err_addr), .err_data(err_data),
    .match_cnt(match_cnt), .ign_cnt(ign_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  int          m_mode;
  int          m_quiet;
  logic [15:0] m_mcnt, m_icnt;
  logic        m_ovf;
  logic [1:0]  m_ecode;
  logic [31:0] m_eaddr, m_edata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_flush();
    mq.delete();
    m_mode = M_IDLE; m_quiet = 0; m_mcnt = 0; m_icnt = 0;
    m_ovf = 0; m_ecode = 0; m_eaddr = 0; m_edata = 0;
  endtask

  // One clock of the reference: verdict rules first, then queue admission.
  task automatic m_advance();
    int   mode0;
    ent_t e;
    mode0 = m_mode;
    if (clear) begin
      m_flush();
      return;
    end
    case (m_mode)
      M_IDLE: if (start) begin
        m_mode = M_RUN; m_mcnt = 0; m_icnt = 0; m_quiet = 0;
      end
      M_RUN: begin
        if (mq.size() == 0) m_mode = M_PASS;
        else if (memwrite && dataadr != IGN) begin
          if (dataadr == mq[0].a && writedata == mq[0].d) begin
            e = mq.pop_front();
            if (m_mcnt != 16'hFFFF) m_mcnt++;
            m_quiet = 0;
          end else begin
            m_mode = M_FAIL; m_ecode = 1; m_eaddr = dataadr; m_edata = writedata;
          end
        end else begin
          if (memwrite && m_icnt != 16'hFFFF) m_icnt++;
          m_quiet++;
          if (m_quiet >= TIMEOUT) begin
            m_mode = M_FAIL; m_ecode = 2;
          end
        end
      end
      default: ;
    endcase
    if (exp_push && (mode0 == M_IDLE || mode0 == M_RUN)) begin
      if (mq.size() < DEPTH) begin
        e.a = exp_addr; e.d = exp_data;
        mq.push_back(e);
      end else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    chk("exp_full", exp_full, mq.size() == DEPTH);
    chk("done", done, m_mode == M_PASS || m_mode == M_FAIL);
    chk("pass", pass, m_mode == M_PASS);
    chk("fail", fail, m_mode == M_FAIL);
    chk("err_code", err_code, m_ecode);
    chk("err_addr", err_addr, m_eaddr);
    chk("err_data", err_data, m_edata);
    chk("match_cnt", match_cnt, m_mcnt);
    chk("ign_cnt", ign_cnt, m_icnt);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic step();
    m_advance();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_flush();
    #2;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d);
    exp_push = 1'b1; exp_addr = a; exp_data = d;
    step();
    exp_push = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step();
    memwrite = 1'b0;
    writedata = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset();

    // Ignored scratch store followed by the single expected store.
    push_one(32'd84, 32'd7);
    pulse_start();
    store(32'd80, 32'h55);
    store(32'd84, 32'd7);
    idle(1);
    chk("t1_pass", pass, 1);
    chk("t1_ign", ign_cnt, 1);
    chk("t1_match", match_cnt, 1);
    chk("t1_err", err_code, 0);

    // Data mismatch captured.
    pulse_clear();
    push_one(32'd84, 32'd7);
    pulse_start();
    store(32'd84, 32'd8);
    chk("t2_fail", fail, 1);
    chk("t2_code", err_code, 1);
    chk("t2_addr", err_addr, 84);
    chk("t2_data", err_data, 8);

    // Timeout after exactly TIMEOUT quiet RUN cycles.
    pulse_clear();
    push_one(32'd84, 32'd7);
    pulse_start();
    idle(TIMEOUT - 1);
    chk("t3_fail_early", fail, 0);
    idle(1);
    chk("t3_fail", fail, 1);
    chk("t3_code", err_code, 2);

    // Overflow: ninth push dropped, eight retained in order.
    pulse_clear();
    for (int i = 0; i < 9; i++) begin
      push_one(32'd100 + 32'(4 * i), 32'(i));
      if (i == 7) begin
        chk("t4_full", exp_full, 1);
        chk("t4_noovf", overflow, 0);
      end
    end
    chk("t4_ovf", overflow, 1);
    pulse_start();
    for (int i = 0; i < 8; i++) store(32'd100 + 32'(4 * i), 32'(i));
    idle(1);
    chk("t4_pass", pass, 1);
    chk("t4_match", match_cnt, 8);

    // Stores after PASS are ignored.
    pulse_clear();
    push_one(32'd4, 32'd1);
    push_one(32'd8, 32'd2);
    pulse_start();
    store(32'd4, 32'd1);
    store(32'd8, 32'd2);
    idle(1);
    chk("t5_pass", pass, 1);
    store(32'd4, 32'd1);
    chk("t5_match", match_cnt, 2);
    chk("t5_still", pass, 1);

    // Asynchronous reset mid-RUN, then clear out of PASS.
    pulse_clear();
    push_one(32'd4, 32'd1);
    push_one(32'd8, 32'd2);
    pulse_start();
    store(32'd4, 32'd1);
    chk("t6_match1", match_cnt, 1);
    do_reset();
    chk("t6_rst_match", match_cnt, 0);
    chk("t6_rst_done", done, 0);
    push_one(32'd4, 32'd1);
    pulse_start();
    store(32'd4, 32'd1);
    idle(1);
    chk("t6_pass", pass, 1);
    pulse_clear();
    chk("t6_clr_done", done, 0);
    chk("t6_clr_match", match_cnt, 0);

    // Randomized traffic.
    for (int s = 0; s < 40; s++) begin
      int n;
      int r;
      pulse_clear();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) push_one(32'(4 * $urandom_range(1, 30)), 32'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        exp_push = 1'b1; exp_addr = 32'(4 * $urandom_range(1, 30)); exp_data = 32'($urandom_range(0, 15));
      end
      pulse_start();
      exp_push = 1'b0;
      for (int c = 0; c < 150 && !(m_mode == M_PASS || m_mode == M_FAIL); c++) begin
        r = $urandom_range(0, 99);
        if (r < 50 && mq.size() > 0) store(mq[0].a, mq[0].d);
        else if (r < 60) store(IGN, $urandom);
        else if (r < 63 && mq.size() > 0) store(mq[0].a, mq[0].d ^ 32'h1);
        else if (r < 68) begin
          exp_push = 1'b1; exp_addr = 32'(4 * $urandom_range(1, 30)); exp_data = 32'($urandom_range(0, 15));
          step();
          exp_push = 1'b0;
        end
        else idle(1);
      end
      idle(2);
      store($urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
